// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler and its datapath.
package alu_pkg;
  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Index of the candidate `ofs` places after pointer `p` among `n`, wrapping.
  function automatic int rr_idx(input int p, input int ofs, input int n);
    return (p + ofs) % n;
  endfunction
endpackage

// File: rtl/alu_core.sv
// Combinational 4-op ALU: op demux selects one of adder, subtractor, AND, OR units.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  logic [3:0]        sel;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] and_v;
  logic [DATA_W-1:0] or_v;

  always_comb begin
    sel = '0;
    case (op)
      ADD:     sel[0] = 1'b1;
      SUB:     sel[1] = 1'b1;
      AND:     sel[2] = 1'b1;
      default: sel[3] = 1'b1;
    endcase
  end

  // One extra bit gives carry for ADD and borrow (a<b) for SUB.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign and_v = a & b;
  assign or_v  = a | b;

  always_comb begin
    result = ({DATA_W{sel[0]}} & sum[DATA_W-1:0])
           | ({DATA_W{sel[1]}} & diff[DATA_W-1:0])
           | ({DATA_W{sel[2]}} & and_v)
           | ({DATA_W{sel[3]}} & or_v);
    carry  = (sel[0] & sum[DATA_W]) | (sel[1] & diff[DATA_W]);
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter plus IDLE/EXEC/RESP sequencer sharing one alu_core among N_REQ sources.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int N_REQ  = 2,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [N_REQ-1:0][OP_W-1:0]    req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_result,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_carry,
  output logic                          rsp_zero
);
  sched_state_e      state, state_nxt;
  logic [ID_W-1:0]   prio;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic              hs;
  logic [DATA_W-1:0] a_q, b_q;
  alu_op_e           op_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // First valid requester at or after prio, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'(rr_idx(int'(prio), i, N_REQ));
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign hs = (state == IDLE) && gnt_found;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= ADD;
      id_q <= '0;
    end else if (hs) begin
      prio <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      a_q  <= req_a[gnt_idx];
      b_q  <= req_b[gnt_idx];
      op_q <= alu_op_e'(req_op[gnt_idx]);
      id_q <= gnt_idx;
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // Response fields load only in EXEC, so they hold steady through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_id     <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result <= alu_res;
      rsp_id     <= id_q;
      rsp_carry  <= alu_carry;
      rsp_zero   <= (alu_res == '0);
    end
  end
endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Shares one 4-operation ALU datapath (ADD/SUB/AND/OR) among N_REQ requesters. A round-robin arbiter grants one request at a time, and a three-state sequencer captures the operands and executes the op. The result is presented with id and flags on a valid/ready response port. The block sits between the command sources and the ALU core, and is the only path by which the core is used.

## Interface
- DATA_W, 4: operand/result width
- N_REQ, 2: number of requesters (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  [N_REQ]  request pending per requester
- req_ready  out  [N_REQ]  request accepted this cycle (one-hot or zero)
- req_a  in  [N_REQ][DATA_W]  operand A per requester
- req_b  in  [N_REQ][DATA_W]  operand B per requester
- req_op  in  [N_REQ][2]  op code: 00 ADD, 01 SUB, 10 AND, 11 OR
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  registered result
- rsp_id  out  $clog2(N_REQ)  index of the served requester
- rsp_carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); 0 for AND/OR
- rsp_zero  out  1  rsp_result == 0

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first requester with req_valid set, searching from pointer prio upward, wrapping.
  - req_ready[grant] = 1; all other req_ready bits = 0. No valid request → req_ready all 0.
  - On handshake: latch a, b, op and id; prio ← (grant+1) mod N_REQ; go to EXEC.
- EXEC: compute on the latched operands. Register result, carry, zero and id into the rsp_* outputs. Go to RESP.
- RESP: rsp_valid = 1. Go to IDLE on the cycle rsp_ready = 1; otherwise hold. While in RESP, rsp_* are stable and req_ready is 0.
- Arithmetic is modulo 2^DATA_W. Carry/borrow is computed on DATA_W+1 bits.
- req_ready is a combinational function of state, prio and req_valid. It has no dependence on rsp_ready.
- Requester inputs are ignored outside the IDLE handshake cycle. A requester may drop req_valid before it is granted.
- prio wraps from N_REQ-1 to 0. prio advances only on a handshake.

## Timing
- Reset values: state IDLE, prio 0, req_ready 0, rsp_valid 0, rsp_result 0, rsp_id 0, rsp_carry 0, rsp_zero 0.
- Handshake in cycle T → rsp_valid high from cycle T+2.
- Consumer accepts in cycle R (rsp_valid & rsp_ready) → next handshake no earlier than R+1. Peak throughput is one op per 3 cycles.
- rsp_ready held high → rsp_valid is a single-cycle pulse per op.
- rst in any state, including EXEC or RESP, drops the in-flight op with no response. All outputs return to reset values on the next edge.
- If all requesters are continuously valid, grants rotate 0,1,…,N_REQ-1,0. Maximum wait for any requester is N_REQ-1 grants.

## Structure
- Package alu_pkg holds:
  - alu_op_e (ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11)
  - sched_state_e (IDLE, EXEC, RESP)
  - OP_W = 2
- Sub-module alu_core: combinational. Inputs a, b, op; outputs result and carry. It is built from the existing demux, adder, subtractor, AND and OR units plus a result mux. The scheduler instantiates alu_core once.
- Arbiter and FSM stay inline in alu_rr_scheduler.

## Test plan
- Reset, then req0 ADD a=4'h9 b=4'h8 with rsp_ready=1 → req_ready[0] at T, rsp_valid at T+2, result 4'h1, carry 1, zero 0, id 0.
- req1 SUB a=4'h3 b=4'h5 → result 4'hE, carry (borrow) 1, id 1. Then SUB a=4'h5 b=4'h5 → result 0, zero 1, carry 0.
- Both requesters valid continuously, AND/OR ops → grants alternate 0,1,0,1. req1 AND 4'hC & 4'hA → 4'h8. req0 OR 4'hC | 4'hA → 4'hE, carry 0.
- rsp_ready held 0 for 5 cycles in RESP → rsp_* stable, req_ready 0 throughout. One cycle after rsp_ready rises, the next grant appears.
- rst asserted during EXEC → no rsp_valid pulse, all outputs 0, prio 0. With both requesters valid afterwards, req0 is granted first.
- req0 asserts req_valid then drops it before being granted while req1 holds → only req1 is served; no response carries id 0.
